// File: rtl/train_sequencer_pkg.sv
// Shared definitions for the training sequencer and the weight-memory controllers:
// state encoding plus the cycles-per-sample and counter-width derivations.
package train_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int calc_cpc(input int p, input int fo, input int z);
    return (p * fo) / z;
  endfunction

  // Width of an index that counts 0..n-1 (never narrower than one bit).
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int etapos_w(input int frac_bits);
    return $clog2(frac_bits + 2);
  endfunction

  // Width of a counter that reaches n inclusive.
  function automatic int count_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/train_sequencer_if.sv
// Control/status bundle between the training controller and the sequencer.
// Field widths derive from the same layer parameters as the sequencer itself.
interface train_sequencer_if
  import train_sequencer_pkg::*;
#(
  parameter int P             = 16,
  parameter int FO            = 2,
  parameter int Z             = 8,
  parameter int FRAC_BITS     = 10,
  parameter int TOTAL_SAMPLES = 5
);
  localparam int CI_W = idx_w(calc_cpc(P, FO, Z));
  localparam int SC_W = count_w(TOTAL_SAMPLES);
  localparam int EP_W = etapos_w(FRAC_BITS);

  logic            start;
  logic            hold;
  logic            abort;
  logic            busy;
  logic            done;
  logic [CI_W-1:0] cycle_index;
  logic            sample_wrap;
  logic [SC_W-1:0] sample_count;
  logic [EP_W-1:0] etapos;
  logic            up_en;
  logic            act_valid;

  modport master (
    output start, hold, abort,
    input  busy, done, cycle_index, sample_wrap, sample_count, etapos, up_en, act_valid
  );

  modport slave (
    input  start, hold, abort,
    output busy, done, cycle_index, sample_wrap, sample_count, etapos, up_en, act_valid
  );
endinterface

// File: rtl/train_sequencer_eta_decay_counter.sv
// Step-decay learning-rate shift: etapos grows by one (eta halves) every
// ETA_DECAY_SAMPLES completed samples, saturating at FRAC_BITS+1.
module eta_decay_counter
  import train_sequencer_pkg::*;
#(
  parameter int FRAC_BITS         = 10,
  parameter int ETA_INIT_POS      = 3,
  parameter int ETA_DECAY_SAMPLES = 2,
  parameter int EP_W              = etapos_w(FRAC_BITS)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic            step,
  input  logic            clear,
  output logic [EP_W-1:0] etapos
);
  localparam int              DC_W     = idx_w(ETA_DECAY_SAMPLES);
  localparam logic [EP_W-1:0] ETA_MAX  = EP_W'(FRAC_BITS + 1);
  localparam logic [EP_W-1:0] ETA_INIT = EP_W'(ETA_INIT_POS);
  localparam logic [DC_W-1:0] DC_LAST  = DC_W'((ETA_DECAY_SAMPLES == 0) ? 0 : ETA_DECAY_SAMPLES - 1);

  logic [EP_W-1:0] etapos_q, etapos_d;
  logic [DC_W-1:0] decay_cnt_q, decay_cnt_d;

  function automatic logic [EP_W-1:0] sat_inc(input logic [EP_W-1:0] e);
    return (e >= ETA_MAX) ? ETA_MAX : e + 1'b1;
  endfunction

  always_comb begin
    etapos_d    = etapos_q;
    decay_cnt_d = decay_cnt_q;
    if (clear) begin
      etapos_d    = '0;
      decay_cnt_d = '0;
    end else if (load) begin
      etapos_d    = ETA_INIT;
      decay_cnt_d = '0;
    end else if (step && (ETA_DECAY_SAMPLES != 0)) begin
      if (decay_cnt_q == DC_LAST) begin
        decay_cnt_d = '0;
        etapos_d    = sat_inc(etapos_q);
      end else begin
        decay_cnt_d = decay_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      etapos_q    <= '0;
      decay_cnt_q <= '0;
    end else begin
      etapos_q    <= etapos_d;
      decay_cnt_q <= decay_cnt_d;
    end
  end

  assign etapos = etapos_q;

endmodule

// File: rtl/train_sequencer.sv
// Cycle-level controller sequencing one junction's FF/BP/UP sets through a
// training run: weight-memory cycle index, sample boundaries, eta schedule, enables.
module train_sequencer
  import train_sequencer_pkg::*;
#(
  parameter int P                 = 16,
  parameter int FO                = 2,
  parameter int Z                 = 8,
  parameter int FRAC_BITS         = 10,
  parameter int ETA_INIT_POS      = 3,
  parameter int ETA_DECAY_SAMPLES = 2,
  parameter int TOTAL_SAMPLES     = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  train_sequencer_if.slave bus
);
  localparam int CPC  = calc_cpc(P, FO, Z);
  localparam int CI_W = idx_w(CPC);
  localparam int SC_W = count_w(TOTAL_SAMPLES);
  localparam int EP_W = etapos_w(FRAC_BITS);

  localparam logic [CI_W-1:0] CI_LAST  = CI_W'(CPC - 1);
  localparam logic [SC_W-1:0] SC_LAST  = SC_W'(TOTAL_SAMPLES - 1);
  localparam logic [SC_W-1:0] SC_TOTAL = SC_W'(TOTAL_SAMPLES);

  state_e          state_q, state_d;
  logic [CI_W-1:0] ci_q, ci_d;
  logic [SC_W-1:0] sc_q, sc_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            act_valid_q, act_valid_d;
  logic            eta_load, eta_step, eta_clear;
  logic            up_en, sample_wrap;
  logic [EP_W-1:0] etapos;

  always_comb begin
    state_d   = state_q;
    ci_d      = ci_q;
    sc_d      = sc_q;
    eta_load  = 1'b0;
    eta_step  = 1'b0;
    eta_clear = 1'b0;

    up_en       = (state_q == ST_RUN) && !bus.hold;
    sample_wrap = up_en && (ci_q == CI_LAST);

    if (bus.abort) begin
      // sample_count is kept so the host can see how far the run got
      state_d   = ST_IDLE;
      ci_d      = '0;
      eta_clear = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!bus.hold) begin
            if (ci_q == CI_LAST) begin
              ci_d = '0;
              // the final sample ends the run instead of taking a decay step
              if (sc_q == SC_LAST) begin
                state_d   = ST_DONE;
                sc_d      = SC_TOTAL;
                eta_clear = 1'b1;
              end else begin
                sc_d     = sc_q + 1'b1;
                eta_step = 1'b1;
              end
            end else begin
              ci_d = ci_q + 1'b1;
            end
          end
        end
        default: begin
          if (bus.start) begin
            state_d  = ST_RUN;
            ci_d     = '0;
            sc_d     = '0;
            eta_load = 1'b1;
          end
        end
      endcase
    end

    busy_d      = (state_d == ST_RUN);
    done_d      = (state_d == ST_DONE);
    act_valid_d = up_en;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ci_q        <= '0;
      sc_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      act_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ci_q        <= ci_d;
      sc_q        <= sc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      act_valid_q <= act_valid_d;
    end
  end

  eta_decay_counter #(
    .FRAC_BITS        (FRAC_BITS),
    .ETA_INIT_POS     (ETA_INIT_POS),
    .ETA_DECAY_SAMPLES(ETA_DECAY_SAMPLES),
    .EP_W             (EP_W)
  ) u_eta (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (eta_load),
    .step   (eta_step),
    .clear  (eta_clear),
    .etapos (etapos)
  );

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.cycle_index  = ci_q;
  assign bus.sample_wrap  = sample_wrap;
  assign bus.sample_count = sc_q;
  assign bus.etapos       = etapos;
  assign bus.up_en        = up_en;
  assign bus.act_valid    = act_valid_q;

endmodule

// File: doc/train_sequencer.md
Name: train_sequencer

Overview:
- Cycle-level controller that sequences one junction's FF, BP and UP processor sets through a training run.
- Generates the weight-memory cycle index and the per-sample boundary pulse.
- Drives etapos into the UP processor set, with a step-decay learning-rate schedule (eta halves every eta_decay_samples inputs).
- Provides the enables that gate updates and the act_function output-valid, which is delayed 1 cycle to match the clocked sigmoid LUT.

Parameters:
- p, 16, neurons in preceding layer.
- fo, 2, fan-out.
- z, 8, weights processed per cycle.
- frac_bits, 10, fractional bits; etapos saturates at frac_bits+1.
- cpc, p*fo/z, cycles per input sample (derived; must be >=2).
- eta_init_pos, 3, etapos loaded on start (1..frac_bits+1; eta = 2^-(etapos-1)).
- eta_decay_samples, 2, samples between etapos increments; 0 disables decay.
- total_samples, 5, samples per run (>=1).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  1-cycle pulse; begins a run from IDLE or DONE.
- hold  in  1  freezes sequencing (upstream data not ready).
- abort  in  1  synchronous; ends the run and returns to IDLE.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- cycle_index  out  $clog2(cpc)  weight-memory address / cycle within the sample.
- sample_wrap  out  1  high during the cycle where cycle_index==cpc-1 and the index advances.
- sample_count  out  $clog2(total_samples+1)  completed samples.
- etapos  out  $clog2(frac_bits+2)  learning-rate shift for UP set; 0 = no update.
- up_en  out  1  enables UP writeback this cycle.
- act_valid  out  1  FF act_out/adot_out valid (up_en delayed 1 cycle).

Behaviour:
- Reset (async, reset_n=0): state=IDLE; every output and internal counter is 0 (busy, done, cycle_index, sample_wrap, sample_count, etapos, up_en, act_valid, decay_cnt). Reset mid-run discards all progress.
- States are IDLE, RUN and DONE. All outputs are registered, except sample_wrap and up_en, which are combinational from registered state and hold.
- IDLE:
  - start=1 -> RUN next cycle.
  - On that edge: cycle_index=0, sample_count=0, decay_cnt=0, etapos=eta_init_pos.
- RUN:
  - up_en = !hold.
  - Each rising edge with hold=0: cycle_index increments.
  - At cpc-1, cycle_index wraps to 0 and sample_count increments.
  - sample_wrap = (cycle_index==cpc-1) & !hold.
  - hold=1: all counters and etapos freeze, up_en=0, sample_wrap=0. hold has priority over wrap.
- Decay (RUN only, on a wrap edge):
  - If eta_decay_samples!=0 and decay_cnt==eta_decay_samples-1: decay_cnt=0 and etapos=min(etapos+1, frac_bits+1).
  - Otherwise decay_cnt increments.
  - Saturation: etapos never exceeds frac_bits+1 and never wraps.
- End of run:
  - On the wrap edge with sample_count==total_samples-1: state=DONE, sample_count=total_samples, etapos=0, cycle_index=0.
  - The final sample's decay step is skipped.
- DONE: done=1, up_en=0. start -> RUN with the same load as from IDLE. abort -> IDLE.
- start while in RUN is ignored.
- abort=1 (any state) -> IDLE next edge, with cycle_index=0, etapos=0, done=0. sample_count keeps its value.
- Priority: abort > start. abort > hold.
- act_valid <= up_en, registered. It is cleared by reset; it is not cleared by abort, since the in-flight LUT result remains valid.
- etapos=0 outside RUN guarantees UP produces zero delta before operation starts and after it ends.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the cpc and etapos-width derivation functions, reused by the memory controllers.
- One natural sub-module, eta_decay_counter: decay_cnt plus saturating etapos, with load/step/clear inputs.

Test Plan (defaults: cpc=4):
1. Reset then idle: reset_n=0 for 3 cycles, then release -> all outputs 0. start=0 for 10 cycles -> outputs stay 0.
2. Full run: start at cycle 0.
   - cycle_index runs 0,1,2,3,0...
   - sample_wrap at cycles 4, 8, 12, 16, 20.
   - etapos = 3, 3 until the 2nd wrap, then 4, then 5 after the 4th wrap.
   - DONE after 5th wrap: done=1, sample_count=5, etapos=0.
   - act_valid trails up_en by exactly 1 cycle.
3. Hold on wrap: hold=1 while cycle_index=3 for 3 cycles -> index stays 3, sample_wrap=0, up_en=0, etapos unchanged. Release -> wrap occurs next edge.
4. Saturation: eta_init_pos=10, frac_bits=10, eta_decay_samples=1, total_samples=5 -> etapos 10, 11, 11, 11, 11 on successive samples, never 12 or 0 during RUN.
5. Abort/reset mid-run:
   - abort at cycle 6 -> IDLE next edge, etapos=0, busy=0. A subsequent start reloads etapos=3.
   - Separately, reset_n=0 mid-cycle -> outputs 0 asynchronously, before the next clock edge.
6. Restart and simultaneous events: in DONE, start -> RUN with sample_count=0. In RUN, start pulse -> no effect. abort+start together -> IDLE.
